mips_multicycle_ctrl: RTL and testbench

Multicycle MIPS control FSM that sits upstream of the datapath ALU and drives its 3-bit operation select, along with every datapath and memory enable. It sequences fetch, decode, execute, memory and writeback for the supported instruction subset. It stalls on a memory ready handshake and flags illegal opcodes and memory timeouts.

---
 rtl/mips_multicycle_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/mem/writeback.
// Ports: clk, rst_n, opcode, funct, zero, mem_ready in; datapath/mem enables, ALU op, status pulses out.
module mips_multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] alu_control_signal,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_source,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       illegal,
  output logic       bus_error
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_R_EXEC,
    S_R_WB,
    S_I_EXEC,
    S_I_WB,
    S_BRANCH,
    S_JUMP
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic       TMO_EN  = (MEM_TIMEOUT != 0);
  localparam logic [7:0] TMO_VAL = MEM_TIMEOUT[7:0];

  state_t     state;
  state_t     state_nx;
  logic [7:0] wait_cnt;
  logic       wait_inc;
  logic       timeout;
  logic       is_store;
  logic       op_r;
  logic       op_mem;
  logic       op_addi;
  logic       op_beq;
  logic       op_j;
  logic       fn_ok;

  assign timeout = TMO_EN && (wait_cnt == TMO_VAL) && !mem_ready;

  assign op_r    = (opcode == 6'h00);
  assign op_mem  = (opcode == 6'h23) || (opcode == 6'h2B);
  assign op_addi = (opcode == 6'h08);
  assign op_beq  = (opcode == 6'h04);
  assign op_j    = (opcode == 6'h02);

  always_comb begin
    fn_ok = 1'b0;
    case (funct)
      6'h20, 6'h22, 6'h24,
      6'h27, 6'h2A, 6'h00: fn_ok = 1'b1;
      default:             fn_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_nx           = state;
    wait_inc           = 1'b0;
    alu_control_signal = ALU_ADD;
    alu_src_a          = 1'b0;
    alu_src_b          = 2'b00;
    iord               = 1'b0;
    mem_read           = 1'b0;
    mem_write          = 1'b0;
    ir_write           = 1'b0;
    pc_en              = 1'b0;
    pc_source          = 2'b00;
    reg_write          = 1'b0;
    reg_dst            = 1'b0;
    mem_to_reg         = 1'b0;
    instr_done         = 1'b0;
    illegal            = 1'b0;
    bus_error          = 1'b0;
    case (state)
      S_IDLE: state_nx = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) begin
          state_nx = S_DECODE;
        end else if (timeout) begin
          bus_error = 1'b1;
          state_nx  = S_IDLE;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        unique case (1'b1)
          op_r && fn_ok: state_nx = S_R_EXEC;
          op_mem:        state_nx = S_MEM_ADDR;
          op_addi:       state_nx = S_I_EXEC;
          op_beq:        state_nx = S_BRANCH;
          op_j:          state_nx = S_JUMP;
          default: begin
            illegal  = 1'b1;
            state_nx = S_FETCH;
          end
        endcase
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        case (funct)
          6'h22:   alu_control_signal = ALU_SUB;
          6'h24:   alu_control_signal = ALU_AND;
          6'h27:   alu_control_signal = ALU_NOR;
          6'h2A:   alu_control_signal = ALU_SLT;
          6'h00:   alu_control_signal = ALU_SLL;
          default: alu_control_signal = ALU_ADD;
        endcase
        state_nx = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_nx  = S_I_WB;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_nx  = is_store ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) begin
          state_nx = S_MEM_WB;
        end else if (timeout) begin
          bus_error = 1'b1;
          state_nx  = S_IDLE;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      S_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_nx   = S_FETCH;
        end else if (timeout) begin
          bus_error = 1'b1;
          state_nx  = S_IDLE;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_BRANCH: begin
        alu_src_a          = 1'b1;
        alu_control_signal = ALU_SUB;
        pc_source          = 2'b01;
        pc_en              = zero;
        instr_done         = 1'b1;
        state_nx           = S_FETCH;
      end
      S_JUMP: begin
        pc_source  = 2'b10;
        pc_en      = 1'b1;
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Counter stays zero outside wait states, so every entry starts from 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= 8'd0;
      is_store <= 1'b0;
    end else begin
      state <= state_nx;
      if (wait_inc) begin
        if (wait_cnt != 8'hFF) begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end else begin
        wait_cnt <= 8'd0;
      end
      // lw/sw choice is captured here so MEM_ADDR need not see opcode.
      if (state == S_DECODE) begin
        is_store <= (opcode == 6'h2B);
      end
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed, table-driven bench for mips_multicycle_ctrl.
// Per-cycle vectors plus hand sequences for waits, timeouts and async reset.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic [2:0] alu_control_signal;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       pc_en;
  logic [1:0] pc_source;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       instr_done;
  logic       illegal;
  logic       bus_error;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .opcode             (opcode),
    .funct              (funct),
    .zero               (zero),
    .mem_ready          (mem_ready),
    .alu_control_signal (alu_control_signal),
    .alu_src_a          (alu_src_a),
    .alu_src_b          (alu_src_b),
    .iord               (iord),
    .mem_read           (mem_read),
    .mem_write          (mem_write),
    .ir_write           (ir_write),
    .pc_en              (pc_en),
    .pc_source          (pc_source),
    .reg_write          (reg_write),
    .reg_dst            (reg_dst),
    .mem_to_reg         (mem_to_reg),
    .instr_done         (instr_done),
    .illegal            (illegal),
    .bus_error          (bus_error)
  );

  logic [18:0] act;
  assign act = {alu_control_signal, alu_src_a, alu_src_b, iord,
                mem_read, mem_write, ir_write, pc_en, pc_source,
                reg_write, reg_dst, mem_to_reg, instr_done,
                illegal, bus_error};

  typedef struct {
    string       name;
    logic        mr;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic [18:0] exp;
  } vec_t;

  vec_t vt[$];

  function automatic logic [18:0] o(
    input logic [2:0] alu, input logic sa, input logic [1:0] sb,
    input logic io, input logic mrd, input logic mwr,
    input logic irw, input logic pce, input logic [1:0] pcs,
    input logic rw, input logic rd, input logic m2r,
    input logic dn, input logic ill, input logic be);
    return {alu, sa, sb, io, mrd, mwr, irw, pce, pcs,
            rw, rd, m2r, dn, ill, be};
  endfunction

  task automatic check(input string nm, input logic [18:0] e);
    n_chk++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, e);
    end
  endtask

  task automatic step(input string nm, input logic mr,
                      input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic [18:0] e);
    mem_ready = mr;
    opcode    = op;
    funct     = fn;
    zero      = z;
    #1;
    check(nm, e);
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input string nm, input logic mr,
                              input logic [5:0] op, input logic [5:0] fn,
                              input logic z, input logic [18:0] e);
    vec_t v;
    v.name = nm;
    v.mr   = mr;
    v.op   = op;
    v.fn   = fn;
    v.z    = z;
    v.exp  = e;
    vt.push_back(v);
  endfunction

  logic [18:0] w_zero, w_f1, w_f0, w_dec, w_ill, w_addr, w_mrd;
  logic [18:0] w_mwb, w_mwr0, w_mwr1, w_rwb, w_iwb, w_jmp;
  logic [18:0] w_br1, w_br0, w_fto, w_mrd_to;

  function automatic logic [18:0] rex(input logic [2:0] alu);
    return o(alu, 1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
  endfunction

  initial begin
    w_zero   = '0;
    w_f1     = o(3'd0, 0, 2'b01, 0, 1, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0);
    w_f0     = o(3'd0, 0, 2'b01, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    w_fto    = o(3'd0, 0, 2'b01, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
    w_dec    = o(3'd0, 0, 2'b11, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    w_ill    = o(3'd0, 0, 2'b11, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0);
    w_addr   = o(3'd0, 1, 2'b10, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    w_mrd    = o(3'd0, 0, 2'b00, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    w_mrd_to = o(3'd0, 0, 2'b00, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
    w_mwb    = o(3'd0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 0, 1, 1, 0, 0);
    w_mwr0   = o(3'd0, 0, 2'b00, 1, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    w_mwr1   = o(3'd0, 0, 2'b00, 1, 0, 1, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0);
    w_rwb    = o(3'd0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 1, 0, 0);
    w_iwb    = o(3'd0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 1, 0, 0);
    w_jmp    = o(3'd0, 0, 2'b00, 0, 0, 0, 0, 1, 2'b10, 0, 0, 0, 1, 0, 0);
    w_br1    = o(3'd1, 1, 2'b00, 0, 0, 0, 0, 1, 2'b01, 0, 0, 0, 1, 0, 0);
    w_br0    = o(3'd1, 1, 2'b00, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 1, 0, 0);

    add("idle",       1, 6'h00, 6'h00, 0, w_zero);
    add("fetch",      1, 6'h00, 6'h00, 0, w_f1);
    add("dec_sub",    1, 6'h00, 6'h22, 0, w_dec);
    add("rex_sub",    1, 6'h00, 6'h22, 0, rex(3'd1));
    add("rwb_sub",    1, 6'h00, 6'h22, 0, w_rwb);
    add("fetch_lw",   1, 6'h00, 6'h00, 0, w_f1);
    add("dec_lw",     1, 6'h23, 6'h00, 0, w_dec);
    add("addr_lw",    1, 6'h23, 6'h00, 0, w_addr);
    add("mrd_w1",     0, 6'h23, 6'h00, 0, w_mrd);
    add("mrd_w2",     0, 6'h23, 6'h00, 0, w_mrd);
    add("mrd_w3",     0, 6'h23, 6'h00, 0, w_mrd);
    add("mrd_rdy",    1, 6'h23, 6'h00, 0, w_mrd);
    add("mwb",        1, 6'h23, 6'h00, 0, w_mwb);
    add("fetch_sw",   1, 6'h00, 6'h00, 0, w_f1);
    add("dec_sw",     1, 6'h2B, 6'h00, 0, w_dec);
    add("addr_sw",    1, 6'h23, 6'h00, 0, w_addr);
    add("mwr_wait",   0, 6'h23, 6'h00, 0, w_mwr0);
    add("mwr_rdy",    1, 6'h23, 6'h00, 0, w_mwr1);
    add("fetch_bt",   1, 6'h00, 6'h00, 0, w_f1);
    add("dec_beq",    1, 6'h04, 6'h00, 1, w_dec);
    add("beq_taken",  1, 6'h04, 6'h00, 1, w_br1);
    add("fetch_bn",   1, 6'h00, 6'h00, 0, w_f1);
    add("dec_beq2",   1, 6'h04, 6'h00, 0, w_dec);
    add("beq_not",    1, 6'h04, 6'h00, 0, w_br0);
    add("fetch_ill",  1, 6'h00, 6'h00, 0, w_f1);
    add("ill_op",     1, 6'h3F, 6'h00, 0, w_ill);
    add("fetch_ill2", 1, 6'h00, 6'h00, 0, w_f1);
    add("ill_funct",  1, 6'h00, 6'h3F, 0, w_ill);
    add("fetch_ad",   1, 6'h00, 6'h00, 0, w_f1);
    add("dec_addi",   1, 6'h08, 6'h00, 0, w_dec);
    add("iex",        1, 6'h08, 6'h00, 0, w_addr);
    add("iwb",        1, 6'h08, 6'h00, 0, w_iwb);
    add("fetch_j",    1, 6'h00, 6'h00, 0, w_f1);
    add("dec_j",      1, 6'h02, 6'h00, 0, w_dec);
    add("jump",       1, 6'h02, 6'h00, 0, w_jmp);
    add("fetch_slt",  1, 6'h00, 6'h00, 0, w_f1);
    add("dec_slt",    1, 6'h00, 6'h2A, 0, w_dec);
    add("rex_slt",    1, 6'h00, 6'h2A, 0, rex(3'd5));
    add("rwb_slt",    1, 6'h00, 6'h2A, 0, w_rwb);
    add("fetch_and",  1, 6'h00, 6'h00, 0, w_f1);
    add("dec_and",    1, 6'h00, 6'h24, 0, w_dec);
    add("rex_and",    1, 6'h00, 6'h24, 0, rex(3'd4));
    add("rwb_and",    1, 6'h00, 6'h24, 0, w_rwb);
    add("fetch_nor",  1, 6'h00, 6'h00, 0, w_f1);
    add("dec_nor",    1, 6'h00, 6'h27, 0, w_dec);
    add("rex_nor",    1, 6'h00, 6'h27, 0, rex(3'd3));
    add("rwb_nor",    1, 6'h00, 6'h27, 0, w_rwb);
    add("fetch_sll",  1, 6'h00, 6'h00, 0, w_f1);
    add("dec_sll",    1, 6'h00, 6'h00, 0, w_dec);
    add("rex_sll",    1, 6'h00, 6'h00, 0, rex(3'd2));
    add("rwb_sll",    1, 6'h00, 6'h00, 0, w_rwb);
    add("fetch_add",  1, 6'h00, 6'h00, 0, w_f1);
    add("dec_add",    1, 6'h00, 6'h20, 0, w_dec);
    add("rex_add",    1, 6'h00, 6'h20, 0, rex(3'd0));
    add("rwb_add",    1, 6'h00, 6'h20, 0, w_rwb);

    rst_n     = 1'b0;
    mem_ready = 1'b0;
    opcode    = 6'h00;
    funct     = 6'h00;
    zero      = 1'b0;
    #1;
    check("reset_outputs", w_zero);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      step(vt[i].name, vt[i].mr, vt[i].op, vt[i].fn, vt[i].z, vt[i].exp);
    end

    // Fetch timeout: error on the 16th stalled cycle, then IDLE.
    for (int i = 0; i < 16; i++) begin
      step($sformatf("fetch_to_%0d", i), 0, 6'h00, 6'h00, 0,
           (i == 15) ? w_fto : w_f0);
    end
    step("idle_after_to", 0, 6'h00, 6'h00, 0, w_zero);

    // mem_ready arriving on the timeout cycle wins.
    for (int i = 0; i < 15; i++) begin
      step($sformatf("fetch_tie_%0d", i), 0, 6'h00, 6'h00, 0, w_f0);
    end
    step("fetch_tie_rdy", 1, 6'h00, 6'h00, 0, w_f1);
    step("dec_after_tie", 1, 6'h2B, 6'h00, 0, w_dec);
    step("addr_sw2", 0, 6'h2B, 6'h00, 0, w_addr);

    // Async reset during MEM_WR, no clock edge in between.
    mem_ready = 1'b0;
    #1;
    check("mwr_before_rst", w_mwr0);
    #1;
    rst_n = 1'b0;
    #1;
    check("mwr_async_rst", w_zero);
    @(negedge clk);
    rst_n = 1'b1;
    step("idle_post_rst", 1, 6'h00, 6'h00, 0, w_zero);
    step("fetch_post_rst", 1, 6'h00, 6'h00, 0, w_f1);
    step("dec_lw_to", 1, 6'h23, 6'h00, 0, w_dec);
    step("addr_lw_to", 1, 6'h23, 6'h00, 0, w_addr);

    // Load timeout inside MEM_RD.
    for (int i = 0; i < 16; i++) begin
      step($sformatf("mrd_to_%0d", i), 0, 6'h23, 6'h00, 0,
           (i == 15) ? w_mrd_to : w_mrd);
    end
    step("idle_after_mrd_to", 0, 6'h00, 6'h00, 0, w_zero);
    step("fetch_after_mrd_to", 1, 6'h00, 6'h00, 0, w_f1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
